hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the stall counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high; clock clk.
REQ-004 IR_D  input  32  instruction in the decode stage; bits 31:26 are op, 25:21 rs, 20:16 rt, 15:11 rd, 5:0 func.
REQ-005 Tuse_RS0, Tuse_RS1  input  1 each  rs is needed in D (Tuse 0) or in E (Tuse 1).
REQ-006 Tuse_RT0, Tuse_RT1, Tuse_RT2  input  1 each  rt is needed at Tuse 0, 1 or 2.
REQ-007 Tnew_E, Tnew_M, Tnew_W  input  2 each  cycles until the E, M or W stage result is ready.
REQ-008 stall  output  1  freezes PC and the D register and turns the next E entry into a bubble.
REQ-009 fwd_rs_D, fwd_rt_D  output  2 each  D-operand source: 0 = GRF, 1 = W, 2 = M, 3 = E.
REQ-010 fwd_rs_E, fwd_rt_E  output  2 each  E-operand source: 0 = pipeline register, 1 = W, 2 = M.
REQ-011 fwd_rt_M  output  1  M store data source: 0 = pipeline register, 1 = W.
REQ-012 stall_cnt  output  CNT_W  count of stalled cycles.

Function
REQ-013 The D-stage destination A3_D SHALL be rd for addu/subu, rt for ori/lui/lw, 31 for jal, and 0 for every other instruction, including nop and undefined encodings.
REQ-014 Each clock SHALL advance the tracking registers as follows: A3_E, rs_E, rt_E <= (stall ? 0 : A3_D, rs_D, rt_D); A3_M <= A3_E; A3_W <= A3_M; rt_M <= rt_E.
REQ-015 Register address 0 SHALL never match for stall or forwarding purposes.
REQ-016 Tuse_rs SHALL be 0 if Tuse_RS0 and 1 if Tuse_RS1; if neither is set, rs has no use and causes no stall. Tuse_rt SHALL be 0, 1 or 2 in the same way.
REQ-017 stall SHALL be asserted combinationally when a used operand X in {rs, rt} satisfies (X==A3_E and Tnew_E>Tuse_X) or (X==A3_M and Tnew_M>Tuse_X).
REQ-018 A W-stage producer SHALL never cause a stall.
REQ-019 fwd_*_D SHALL choose E (3) if X==A3_E and Tnew_E==0, else M (2) if X==A3_M and Tnew_M==0, else W (1) if X==A3_W, else 0; the youngest producer wins.
REQ-020 fwd_*_E SHALL choose M (2) if X_E==A3_M and Tnew_M==0, else W (1) if X_E==A3_W, else 0.
REQ-021 fwd_rt_M SHALL be 1 if rt_M==A3_W and rt_M!=0, else 0.
REQ-022 The forwarding outputs SHALL stay valid while stall is high; consumers ignore them for the stalled instruction.
REQ-023 stall_cnt SHALL increment by 1 on each clock edge where stall==1 and reset==0, and SHALL saturate at all-ones with no wrap.
REQ-024 A stall SHALL last exactly until the producer's Tnew falls to Tuse or below: 1 cycle for lw followed by an add-type consumer, 2 cycles for lw followed by beq or jr.
REQ-025 All outputs except stall_cnt SHALL be combinational from the tracking registers and the inputs, with zero latency.

Reset
REQ-026 On reset, A3_E, A3_M, A3_W, rs_E, rt_E, rt_M and stall_cnt SHALL be cleared to 0 on the same edge.
REQ-027 After reset, stall SHALL be 0 and all fwd_* outputs SHALL be 0 while IR_D = nop.
REQ-028 A reset asserted during a stall SHALL discard the pending stall; no counter increment occurs on that edge.

Verification
REQ-029 Scenario: lw $8,0($0), then addu $9,$8,$8 in D (Tnew_E=2, Tuse_RT1) -> stall=1 for one cycle, a bubble in E, stall_cnt=1, then fwd_rs_E=1 and fwd_rt_E=1 (W).
REQ-030 Scenario: lw $8, then beq $8,$0 -> stall=1 for two cycles, then fwd_rs_D=1 (W); stall_cnt=2.
REQ-031 Scenario: ori $5,$0,1; ori $5,$5,2; addu $6,$5,$5 -> no stall; the addu has fwd_rs_E=2 (M, the younger ori) and not W.
REQ-032 Scenario: jal followed by jr $31 in D (Tnew_E=0) -> no stall, fwd_rs_D=3.
REQ-033 Scenario: addu $0,$1,$1 followed by a $0 consumer -> no stall and all fwd_*=0.
REQ-034 Scenario: force stall continuously for 2^CNT_W+3 cycles -> stall_cnt holds at all-ones; a reset pulse then returns it to 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      IR_D;
    logic             Tuse_RS0;
    logic             Tuse_RS1;
    logic             Tuse_RT0;
    logic             Tuse_RT1;
    logic             Tuse_RT2;
    logic [1:0]       Tnew_E;
    logic [1:0]       Tnew_M;
    logic [1:0]       Tnew_W;
    logic             stall;
    logic [1:0]       fwd_rs_D;
    logic [1:0]       fwd_rt_D;
    logic [1:0]       fwd_rs_E;
    logic [1:0]       fwd_rt_E;
    logic             fwd_rt_M;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output IR_D, Tuse_RS0, Tuse_RS1, Tuse_RT0, Tuse_RT1, Tuse_RT2, Tnew_E, Tnew_M, Tnew_W,
        input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt
    );

    modport slave (
        input  IR_D, Tuse_RS0, Tuse_RS1, Tuse_RT0, Tuse_RT1, Tuse_RT2, Tnew_E, Tnew_M, Tnew_W,
        output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: Tuse/Tnew stall decision, operand forwarding select and a
// saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSubu  = 6'h23;

    logic [5:0] op, func;
    logic [4:0] rs_d, rt_d, rd_d, a3_d;
    logic [4:0] a3_e_q, a3_m_q, a3_w_q, rs_e_q, rt_e_q, rt_m_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic       use_rs, use_rt, stall_rs, stall_rt, stall;
    logic [1:0] tuse_rs, tuse_rt;

    assign op   = hz.IR_D[31:26];
    assign rs_d = hz.IR_D[25:21];
    assign rt_d = hz.IR_D[20:16];
    assign rd_d = hz.IR_D[15:11];
    assign func = hz.IR_D[5:0];

    always_comb begin
        a3_d = '0;
        case (op)
            OpRtype: if (func == FnAddu || func == FnSubu) a3_d = rd_d;
            OpOri, OpLui, OpLw: a3_d = rt_d;
            OpJal:   a3_d = 5'd31;
            default: a3_d = '0;
        endcase
    end

    // $0 is never a real dependency.
    function automatic logic hit(input logic [4:0] x, input logic [4:0] a3);
        return (x != 5'd0) && (x == a3);
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic [4:0] x, input logic [4:0] a3e,
                                             input logic [4:0] a3m, input logic [4:0] a3w,
                                             input logic [1:0] tne, input logic [1:0] tnm);
        if (hit(x, a3e) && tne == 2'd0) return 2'd3;
        if (hit(x, a3m) && tnm == 2'd0) return 2'd2;
        if (hit(x, a3w))                return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] x, input logic [4:0] a3m,
                                             input logic [4:0] a3w, input logic [1:0] tnm);
        if (hit(x, a3m) && tnm == 2'd0) return 2'd2;
        if (hit(x, a3w))                return 2'd1;
        return 2'd0;
    endfunction

    always_comb begin
        use_rs  = hz.Tuse_RS0 | hz.Tuse_RS1;
        tuse_rs = hz.Tuse_RS0 ? 2'd0 : 2'd1;
        use_rt  = hz.Tuse_RT0 | hz.Tuse_RT1 | hz.Tuse_RT2;
        tuse_rt = hz.Tuse_RT0 ? 2'd0 : (hz.Tuse_RT1 ? 2'd1 : 2'd2);
        // Only E and M producers can still be in flight; W is always forwardable.
        stall_rs = use_rs && ((hit(rs_d, a3_e_q) && hz.Tnew_E > tuse_rs) ||
                              (hit(rs_d, a3_m_q) && hz.Tnew_M > tuse_rs));
        stall_rt = use_rt && ((hit(rt_d, a3_e_q) && hz.Tnew_E > tuse_rt) ||
                              (hit(rt_d, a3_m_q) && hz.Tnew_M > tuse_rt));
        stall    = stall_rs | stall_rt;
    end

    assign hz.stall     = stall;
    assign hz.fwd_rs_D  = fwd_d_sel(rs_d, a3_e_q, a3_m_q, a3_w_q, hz.Tnew_E, hz.Tnew_M);
    assign hz.fwd_rt_D  = fwd_d_sel(rt_d, a3_e_q, a3_m_q, a3_w_q, hz.Tnew_E, hz.Tnew_M);
    assign hz.fwd_rs_E  = fwd_e_sel(rs_e_q, a3_m_q, a3_w_q, hz.Tnew_M);
    assign hz.fwd_rt_E  = fwd_e_sel(rt_e_q, a3_m_q, a3_w_q, hz.Tnew_M);
    assign hz.fwd_rt_M  = hit(rt_m_q, a3_w_q);
    assign hz.stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a3_e_q      <= '0;
            a3_m_q      <= '0;
            a3_w_q      <= '0;
            rs_e_q      <= '0;
            rt_e_q      <= '0;
            rt_m_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            a3_e_q <= stall ? 5'd0 : a3_d;
            rs_e_q <= stall ? 5'd0 : rs_d;
            rt_e_q <= stall ? 5'd0 : rt_d;
            a3_m_q <= a3_e_q;
            a3_w_q <= a3_m_q;
            rt_m_q <= rt_e_q;
            if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stage-history model checked every cycle, plus literal
// expectations for the classic lw/branch/jal/$0 scenarios and counter saturation.
module tb_hazard_ctrl;
    localparam int unsigned CW = 4;

    localparam logic [31:0] Nop     = 32'h0000_0000;
    localparam logic [31:0] LwR8    = 32'h8C08_0000;  // lw   $8,0($0)
    localparam logic [31:0] AdduR9  = 32'h0108_4821;  // addu $9,$8,$8
    localparam logic [31:0] BeqR8   = 32'h1100_0000;  // beq  $8,$0
    localparam logic [31:0] OriA    = 32'h3405_0001;  // ori  $5,$0,1
    localparam logic [31:0] OriB    = 32'h34A5_0002;  // ori  $5,$5,2
    localparam logic [31:0] AdduR6  = 32'h00A5_3021;  // addu $6,$5,$5
    localparam logic [31:0] Jal     = 32'h0C00_0000;
    localparam logic [31:0] JrR31   = 32'h03E0_0008;
    localparam logic [31:0] AdduZ   = 32'h0021_0021;  // addu $0,$1,$1
    localparam logic [31:0] AdduR2  = 32'h0000_1021;  // addu $2,$0,$0
    localparam logic [31:0] SwR8    = 32'hAC08_0000;  // sw   $8,0($0)

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   run_chk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();
    hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .hz(hz));

    always #5 clk = ~clk;

    // Model: destination written by each in-flight stage (0=E, 1=M, 2=W), plus source regs.
    int m_dst[3];
    int m_rs_e, m_rt_e, m_rt_m, m_cnt;

    function automatic int dest_of(input logic [31:0] ir);
        logic [5:0] o;
        o = ir[31:26];
        if (o == 6'h00) return (ir[5:0] == 6'h21 || ir[5:0] == 6'h23) ? int'(ir[15:11]) : 0;
        if (o == 6'h0d || o == 6'h0f || o == 6'h23) return int'(ir[20:16]);
        if (o == 6'h03) return 31;
        return 0;
    endfunction

    function automatic int tnew(input int s);
        if (s == 0) return int'(hz.Tnew_E);
        if (s == 1) return int'(hz.Tnew_M);
        return int'(hz.Tnew_W);
    endfunction

    function automatic bit m_stall();
        int src[2];
        int tu[2];
        src[0] = int'(hz.IR_D[25:21]);
        src[1] = int'(hz.IR_D[20:16]);
        tu[0] = hz.Tuse_RS0 ? 0 : (hz.Tuse_RS1 ? 1 : -1);
        tu[1] = hz.Tuse_RT0 ? 0 : (hz.Tuse_RT1 ? 1 : (hz.Tuse_RT2 ? 2 : -1));
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 2; s++)
                if (tu[k] >= 0 && src[k] != 0 && src[k] == m_dst[s] && tnew(s) > tu[k])
                    return 1'b1;
        return 1'b0;
    endfunction

    // Youngest stage that can supply x wins; code 3-s names stage s.
    function automatic int m_fwd(input int x, input int first);
        for (int s = first; s < 3; s++)
            if (x != 0 && x == m_dst[s] && (s == 2 || tnew(s) == 0)) return 3 - s;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_dst  <= '{0, 0, 0};
            m_rs_e <= 0;
            m_rt_e <= 0;
            m_rt_m <= 0;
            m_cnt  <= 0;
        end else begin
            bit st;
            st = m_stall();
            m_dst[0] <= st ? 0 : dest_of(hz.IR_D);
            m_dst[1] <= m_dst[0];
            m_dst[2] <= m_dst[1];
            m_rs_e   <= st ? 0 : int'(hz.IR_D[25:21]);
            m_rt_e   <= st ? 0 : int'(hz.IR_D[20:16]);
            m_rt_m   <= m_rt_e;
            if (st && m_cnt < (1 << CW) - 1) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            chk("model.stall", int'(hz.stall), int'(m_stall()));
            chk("model.fwd_rs_D", int'(hz.fwd_rs_D), m_fwd(int'(hz.IR_D[25:21]), 0));
            chk("model.fwd_rt_D", int'(hz.fwd_rt_D), m_fwd(int'(hz.IR_D[20:16]), 0));
            chk("model.fwd_rs_E", int'(hz.fwd_rs_E), m_fwd(m_rs_e, 1));
            chk("model.fwd_rt_E", int'(hz.fwd_rt_E), m_fwd(m_rt_e, 1));
            chk("model.fwd_rt_M", int'(hz.fwd_rt_M), int'(m_rt_m != 0 && m_rt_m == m_dst[2]));
            chk("model.stall_cnt", int'(hz.stall_cnt), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rsu = {RS1,RS0}, rtu = {RT2,RT1,RT0}
    task automatic set_in(input logic [31:0] ir, input logic [1:0] rsu, input logic [2:0] rtu,
                          input logic [1:0] te, input logic [1:0] tm, input logic [1:0] tw);
        hz.IR_D     = ir;
        hz.Tuse_RS0 = rsu[0];
        hz.Tuse_RS1 = rsu[1];
        hz.Tuse_RT0 = rtu[0];
        hz.Tuse_RT1 = rtu[1];
        hz.Tuse_RT2 = rtu[2];
        hz.Tnew_E   = te;
        hz.Tnew_M   = tm;
        hz.Tnew_W   = tw;
        #1;
    endtask

    task automatic do_reset();
        set_in(Nop, 2'b00, 3'b000, 2'd0, 2'd0, 2'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        set_in(Nop, 2'b00, 3'b000, 2'd0, 2'd0, 2'd0);
        tick();
        run_chk = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst.stall", int'(hz.stall), 0);
        chk("rst.fwd_rs_D", int'(hz.fwd_rs_D), 0);
        chk("rst.fwd_rt_D", int'(hz.fwd_rt_D), 0);
        chk("rst.fwd_rs_E", int'(hz.fwd_rs_E), 0);
        chk("rst.fwd_rt_E", int'(hz.fwd_rt_E), 0);
        chk("rst.fwd_rt_M", int'(hz.fwd_rt_M), 0);
        chk("rst.stall_cnt", int'(hz.stall_cnt), 0);

        // lw then addu: one stall cycle, then both operands from W in E.
        set_in(LwR8, 2'b10, 3'b000, 2'd0, 2'd0, 2'd0);
        tick();
        set_in(AdduR9, 2'b10, 3'b010, 2'd2, 2'd0, 2'd0);
        chk("lw_add.stall1", int'(hz.stall), 1);
        tick();
        set_in(AdduR9, 2'b10, 3'b010, 2'd0, 2'd1, 2'd0);
        chk("lw_add.stall2", int'(hz.stall), 0);
        tick();
        set_in(Nop, 2'b00, 3'b000, 2'd1, 2'd0, 2'd0);
        chk("lw_add.fwd_rs_E", int'(hz.fwd_rs_E), 1);
        chk("lw_add.fwd_rt_E", int'(hz.fwd_rt_E), 1);
        chk("lw_add.cnt", int'(hz.stall_cnt), 1);
        tick();

        // lw then beq: two stall cycles, then rs from W in D.
        do_reset();
        set_in(LwR8, 2'b10, 3'b000, 2'd0, 2'd0, 2'd0);
        tick();
        set_in(BeqR8, 2'b01, 3'b001, 2'd2, 2'd0, 2'd0);
        chk("lw_beq.stall1", int'(hz.stall), 1);
        tick();
        set_in(BeqR8, 2'b01, 3'b001, 2'd0, 2'd1, 2'd0);
        chk("lw_beq.stall2", int'(hz.stall), 1);
        tick();
        set_in(BeqR8, 2'b01, 3'b001, 2'd0, 2'd0, 2'd0);
        chk("lw_beq.stall3", int'(hz.stall), 0);
        chk("lw_beq.fwd_rs_D", int'(hz.fwd_rs_D), 1);
        chk("lw_beq.cnt", int'(hz.stall_cnt), 2);
        tick();

        // ori; ori; addu: younger producer in M beats older one in W.
        do_reset();
        set_in(OriA, 2'b10, 3'b000, 2'd0, 2'd0, 2'd0);
        tick();
        set_in(OriB, 2'b10, 3'b000, 2'd1, 2'd0, 2'd0);
        chk("ori.stall_b", int'(hz.stall), 0);
        tick();
        set_in(AdduR6, 2'b10, 3'b010, 2'd1, 2'd0, 2'd0);
        chk("ori.stall_c", int'(hz.stall), 0);
        tick();
        set_in(Nop, 2'b00, 3'b000, 2'd1, 2'd0, 2'd0);
        chk("ori.fwd_rs_E", int'(hz.fwd_rs_E), 2);
        chk("ori.fwd_rt_E", int'(hz.fwd_rt_E), 2);
        tick();

        // jal then jr $31: link value ready in E.
        set_in(Jal, 2'b00, 3'b000, 2'd0, 2'd0, 2'd0);
        tick();
        set_in(JrR31, 2'b01, 3'b000, 2'd0, 2'd0, 2'd0);
        chk("jal.stall", int'(hz.stall), 0);
        chk("jal.fwd_rs_D", int'(hz.fwd_rs_D), 3);
        tick();

        // Write to $0 never creates a dependency.
        set_in(AdduZ, 2'b10, 3'b010, 2'd0, 2'd0, 2'd0);
        tick();
        set_in(AdduR2, 2'b01, 3'b001, 2'd3, 2'd0, 2'd0);
        chk("zero.stall", int'(hz.stall), 0);
        chk("zero.fwd_rs_D", int'(hz.fwd_rs_D), 0);
        chk("zero.fwd_rt_D", int'(hz.fwd_rt_D), 0);
        tick();

        // lw then sw: store data forwarded from W in M.
        set_in(LwR8, 2'b10, 3'b000, 2'd1, 2'd0, 2'd0);
        tick();
        set_in(SwR8, 2'b10, 3'b100, 2'd2, 2'd0, 2'd0);
        chk("sw.stall", int'(hz.stall), 0);
        tick();
        set_in(Nop, 2'b00, 3'b000, 2'd0, 2'd1, 2'd0);
        chk("sw.fwd_rt_E", int'(hz.fwd_rt_E), 0);
        tick();
        set_in(Nop, 2'b00, 3'b000, 2'd0, 2'd0, 2'd0);
        chk("sw.fwd_rt_M", int'(hz.fwd_rt_M), 1);
        tick();

        // Reset while stalled: no count on that edge, stall dropped.
        do_reset();
        set_in(LwR8, 2'b10, 3'b000, 2'd0, 2'd0, 2'd0);
        tick();
        set_in(BeqR8, 2'b01, 3'b001, 2'd2, 2'd0, 2'd0);
        chk("rst_stall.pre", int'(hz.stall), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_stall.cnt", int'(hz.stall_cnt), 0);
        chk("rst_stall.stall", int'(hz.stall), 0);

        // Counter saturation: 20 stalls into a 4-bit counter.
        for (int i = 0; i < 10; i++) begin
            set_in(LwR8, 2'b10, 3'b000, 2'd0, 2'd0, 2'd0);
            tick();
            set_in(BeqR8, 2'b01, 3'b001, 2'd2, 2'd0, 2'd0);
            tick();
            set_in(BeqR8, 2'b01, 3'b001, 2'd0, 2'd1, 2'd0);
            tick();
            set_in(BeqR8, 2'b01, 3'b001, 2'd0, 2'd0, 2'd0);
            tick();
            if (i == 6) chk("sat.cnt14", int'(hz.stall_cnt), 14);
        end
        chk("sat.cnt_max", int'(hz.stall_cnt), 15);
        do_reset();
        chk("sat.cnt_clr", int'(hz.stall_cnt), 0);
        tick();

        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
